// File: rtl/miriscv_div_pkg.sv
// Shared types and helpers for the iterative RV32M divider.
package miriscv_div_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_CNT_W = $clog2(XLEN);

  // Bit 1 selects the remainder, bit 0 selects unsigned operation.
  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // Two's complement negate.
  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

endpackage

// File: rtl/miriscv_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Special cases (divide by zero, signed overflow) finish straight from IDLE;
// everything else iterates XLEN cycles in CALC, then fixes signs in FIX.
module miriscv_div
  import miriscv_div_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            div_req_i,
  input  div_op_t         div_op_i,
  input  logic [XLEN-1:0] div_a_i,
  input  logic [XLEN-1:0] div_b_i,
  input  logic            div_kill_i,
  output logic            div_busy_o,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t           state_q;
  div_state_t           state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]      rem_q;
  logic [XLEN-1:0]      quot_q;
  logic [XLEN-1:0]      divisor_q;
  logic [XLEN-1:0]      result_q;
  logic                 neg_q;
  logic                 rem_sel_q;
  logic                 busy_q;
  logic                 valid_q;

  logic                 accept;
  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [XLEN-1:0]      a_mag;
  logic [XLEN-1:0]      b_mag;
  logic                 div_by_zero;
  logic                 overflow;
  logic                 special;
  logic [XLEN-1:0]      special_result;
  logic                 result_neg;

  logic [XLEN:0]        rem_shift;
  logic [XLEN:0]        trial;
  logic [XLEN-1:0]      rem_next;
  logic [XLEN-1:0]      quot_next;
  logic [XLEN-1:0]      fix_result;

  // Decode the incoming request: operand magnitudes, sign of result, special cases.
  always_comb begin
    accept         = (state_q == IDLE) && div_req_i && !div_kill_i;
    signed_op      = !div_op_i[0];
    a_neg          = signed_op && div_a_i[XLEN-1];
    b_neg          = signed_op && div_b_i[XLEN-1];
    a_mag          = a_neg ? neg(div_a_i) : div_a_i;
    b_mag          = b_neg ? neg(div_b_i) : div_b_i;
    div_by_zero    = (div_b_i == '0);
    overflow       = signed_op && (div_a_i == MIN_NEG) && (div_b_i == '1);
    special        = div_by_zero || overflow;
    result_neg     = div_op_i[1] ? a_neg : (a_neg ^ b_neg);
    special_result = div_a_i;
    if (div_by_zero) begin
      special_result = div_op_i[1] ? div_a_i : '1;
    end else if (div_op_i[1]) begin
      special_result = '0;
    end
  end

  // One restoring step: shift {rem,quot} left, keep the trial difference if non-negative.
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    rem_next  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    quot_next = {quot_q[XLEN-2:0], !trial[XLEN]};
  end

  // Sign-correct the finished magnitudes and pick quotient or remainder.
  always_comb begin
    if (rem_sel_q) begin
      fix_result = neg_q ? neg(rem_q) : rem_q;
    end else begin
      fix_result = neg_q ? neg(quot_q) : quot_q;
    end
  end

  // Next-state logic; kill abandons CALC/FIX but lets a DONE pulse through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (div_kill_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = div_kill_i ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; busy and valid are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  // Datapath registers: operand latch on accept, iteration in CALC, result on FIX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (special) begin
              result_q <= special_result;
            end else begin
              rem_q     <= '0;
              quot_q    <= a_mag;
              divisor_q <= b_mag;
              cnt_q     <= DIV_CNT_W'(XLEN-1);
              neg_q     <= result_neg;
              rem_sel_q <= div_op_i[1];
            end
          end
        end
        CALC: begin
          if (!div_kill_i) begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= cnt_q - DIV_CNT_W'(1);
          end
        end
        FIX: begin
          if (!div_kill_i) begin
            result_q <= fix_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign div_busy_o   = busy_q;
  assign div_valid_o  = valid_q;
  assign div_result_o = result_q;

endmodule

// File: doc/miriscv_div.md
Name: miriscv_div

Overview:
Iterative radix-2 divider implementing RV32M DIV/DIVU/REM/REMU. It sits beside the ALU in the execute stage and takes the same operand buses. It is the multi-cycle counterpart to the ALU's single-cycle arithmetic: it accepts a request, stalls the pipeline while it iterates, then returns one result with a valid pulse. It has one clock and a synchronous, active-high reset.

Parameters:
XLEN, 32 (from miriscv_pkg), operand and result width; must be a power of two, at least 8.

Ports:
clk_i  input  1  core clock; all state updates on the rising edge.
rst_i  input  1  synchronous reset, active-high.
div_req_i  input  1  request strobe; sampled only while idle.
div_op_i  input  2  operation select (div_op_t from package).
div_a_i  input  XLEN  dividend.
div_b_i  input  XLEN  divisor.
div_kill_i  input  1  flush; abandons any in-flight operation.
div_busy_o  output  1  high whenever state is not IDLE; the pipeline stalls on it.
div_valid_o  output  1  one-cycle pulse: result is available.
div_result_o  output  XLEN  quotient or remainder; held stable until the next accept.

Behaviour:
- Reset: state is IDLE. div_busy_o=0, div_valid_o=0, div_result_o=0, and internal counter and registers are 0. Reset overrides kill and req in the same cycle.
- States: IDLE, CALC, FIX, DONE.
- Accept: at an edge where state is IDLE, div_req_i=1 and div_kill_i=0.
  - Operands and op are latched on that edge.
  - div_req_i in any other state is ignored; requests are not queued.
- Signed ops (DIV, REM):
  - Store the magnitudes |a| and |b|.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Unsigned ops (DIVU, REMU): operands are used as-is.
- Special cases are detected at accept and go IDLE->DONE directly, so div_valid_o rises 1 cycle after accept.
  - Divide by zero (b=0): DIV/DIVU return all-ones; REM/REMU return a unchanged.
  - Signed overflow (a=0x8000_0000 for XLEN=32, b=all-ones) with DIV: return a.
  - Signed overflow with REM: return 0.
  - Overflow does not apply to DIVU/REMU.
- Normal path: IDLE->CALC.
  - CALC runs exactly XLEN cycles with a counter from XLEN-1 down to 0.
  - Each cycle is a restoring step: shift {rem,quot} left by 1; trial = rem - divisor (XLEN+1 bits); if trial is non-negative, rem=trial and quotient LSB=1.
  - Counter = 0 -> FIX.
- FIX: one cycle. Apply the sign correction (two's complement negate when the sign flag is set) and select quotient or remainder by op. Register into div_result_o. -> DONE.
- DONE: div_valid_o=1 for exactly this cycle, div_busy_o=1. Next state is IDLE unconditionally.
- Latency: accept edge to valid = XLEN+2 cycles (34 for XLEN=32) on the normal path; 1 cycle for special cases. Minimum spacing between accepts is XLEN+3 cycles.
- Kill:
  - div_kill_i=1 in CALC or FIX -> IDLE on the next edge. No valid pulse; div_result_o keeps its previous value.
  - Kill in DONE: the valid pulse is still shown that cycle and the consumer discards it.
  - Kill in IDLE blocks an accept in the same cycle.
- div_result_o changes only on the FIX edge or the special-case accept edge. Between operations it holds the last result.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- miriscv_div_pkg holds:
  - typedef enum logic [1:0] div_op_t {DIV_DIV=2'b00, DIV_DIVU=2'b01, DIV_REM=2'b10, DIV_REMU=2'b11}. Bit 1 selects the remainder; bit 0 selects unsigned.
  - typedef enum div_state_t {IDLE, CALC, FIX, DONE}.
  - localparam DIV_CNT_W = $clog2(XLEN).
- A separate sub-module is not warranted; the restoring step is a single combinational block in the datapath.
- The negate helper is a function in the package: miriscv_div_pkg::neg(x) = ~x + 1.

Test Plan:
1. DIV a=100, b=7 -> div_result_o=14, valid exactly 34 cycles after accept; busy high throughout. REM with the same operands -> 2.
2. REM a=-7 (0xFFFF_FFF9), b=2 -> 0xFFFF_FFFF (-1). DIV with the same operands -> 0xFFFF_FFFD (-3). DIVU a=0xFFFF_FFF9, b=2 -> 0x7FFF_FFFC.
3. DIVU a=0x1234, b=0 -> 0xFFFF_FFFF. REMU with the same operands -> 0x0000_1234. Valid 1 cycle after accept.
4. DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000 after 1 cycle. REM with the same operands -> 0.
5. Start DIV 100/7, assert div_kill_i at CALC cycle 10 -> IDLE next edge, no valid, result unchanged. An immediate new DIVU 9/3 then returns 3 after 34 cycles.
6. Assert rst_i mid-CALC -> next edge all outputs 0, state IDLE. Assert div_req_i while busy -> ignored; only the original result is returned, with a single valid pulse.
